// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word-organised memory target for the multi-cycle MIPS core
//
// Purpose: answers the core's level-based request port from a 2**ADDR_W x 32
// array. Writes take effect at the sampling edge. Read data is registered
// READ_LAT edges after the request is accepted. The block also raises a sticky
// err flag on protocol violations.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset (array contents kept)
//   mem_addr       in   byte address; word index is mem_addr[ADDR_W+1:2]
//   mem_read       in   read request level, held until data is taken
//   mem_write      in   write request, one-cycle-high level
//   mem_write_data in   write data
//   mem_read_data  out  registered read data, held until the next read or reset
//   busy           out  high while a read is waiting or completed-but-held
//   rd_done        out  one-cycle pulse in the first cycle of new read data
//   err            out  sticky protocol-error flag
module mips_mem_responder #(
   parameter int ADDR_W    = 10,
   parameter int READ_LAT  = 2,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        busy,
   output logic        rd_done,
   output logic        err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

   state_t            state;
   logic [31:0]       mem [0:DEPTH-1];
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        lat_cnt;
   logic [ADDR_W-1:0] word_idx;
   logic              misaligned;
   logic              wr_en;
   logic              unused_addr_bits;

   // Upper address bits beyond the array are dropped, so accesses wrap.
   assign word_idx         = mem_addr[ADDR_W+1:2];
   assign misaligned       = |mem_addr[1:0];
   assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

   // Writes are honoured only in IDLE. When read and write are both high the
   // write still goes through and the FSM flags err.
   assign wr_en = reset && (state == IDLE) && mem_write;

   assign busy = (state != IDLE);

   // The array is not reset, so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[word_idx] <= mem_write_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         mem_read_data <= '0;
         rd_done       <= 1'b0;
         err           <= 1'b0;
         lat_cnt       <= '0;
         rd_addr       <= '0;
      end else begin
         rd_done <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_write) begin
                  if (mem_read || misaligned)
                     err <= 1'b1;
               end else if (mem_read) begin
                  if (misaligned)
                     err <= 1'b1;
                  rd_addr <= word_idx;
                  lat_cnt <= 3'(READ_LAT - 1);
                  if (READ_LAT == 1) begin
                     mem_read_data <= mem[word_idx];
                     rd_done       <= 1'b1;
                     state         <= RD_DONE;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (mem_write)
                  err <= 1'b1;
               if (!mem_read) begin
                  // Initiator gave up early: drop the read, keep old data.
                  err   <= 1'b1;
                  state <= IDLE;
               end else if (lat_cnt == 3'd1) begin
                  mem_read_data <= mem[rd_addr];
                  rd_done       <= 1'b1;
                  state         <= RD_DONE;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            RD_DONE: begin
               if (mem_write)
                  err <= 1'b1;
               // One low sample is required before the next request is seen.
               if (!mem_read)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - self-checking bench for mips_mem_responder at READ_LAT 1, 2 and 4
module tb_mips_mem_responder;

   localparam int LAT [3] = '{1, 2, 4};

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_write_data;
   logic [31:0] rdata [3];
   logic        busy  [3];
   logic        done  [3];
   logic        errf  [3];

   int total = 0;
   int bad   = 0;

   logic [31:0] model [int];

   mips_mem_responder #(.ADDR_W(10), .READ_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_write_data(mem_write_data),
      .mem_read_data(rdata[0]), .busy(busy[0]), .rd_done(done[0]), .err(errf[0]));

   mips_mem_responder #(.ADDR_W(10), .READ_LAT(2)) u_lat2 (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_write_data(mem_write_data),
      .mem_read_data(rdata[1]), .busy(busy[1]), .rd_done(done[1]), .err(errf[1]));

   mips_mem_responder #(.ADDR_W(10), .READ_LAT(4)) u_lat4 (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_write_data(mem_write_data),
      .mem_read_data(rdata[2]), .busy(busy[2]), .rd_done(done[2]), .err(errf[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int widx(input logic [31:0] a);
      return int'((a / 32'd4) % 32'd1024);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #2 reset = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr       = a;
      mem_write_data = d;
      mem_write      = 1'b1;
      tick();
      mem_write      = 1'b0;
      model[widx(a)] = d;
   endtask

   // Holds mem_read long enough for every latency, records the first rd_done
   // cycle of each instance and checks latency, data and the return to idle.
   task automatic do_read(input logic [31:0] a, input logic [31:0] exp,
                          input bit chg, input logic [31:0] alt, input string nm);
      int          seen [3];
      logic [31:0] got  [3];
      for (int i = 0; i < 3; i++) begin
         seen[i] = -1;
         got[i]  = 'x;
      end
      mem_addr = a;
      mem_read = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (t == 1 && chg)
            mem_addr = alt;
         for (int i = 0; i < 3; i++)
            if (done[i] === 1'b1 && seen[i] < 0) begin
               seen[i] = t;
               got[i]  = rdata[i];
            end
      end
      mem_read = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (seen[i] != LAT[i]) begin
            bad++;
            $display("FAIL %s latency lat%0d: got %0d want %0d", nm, LAT[i], seen[i], LAT[i]);
         end
         total++;
         if (got[i] !== exp) begin
            bad++;
            $display("FAIL %s data lat%0d: got %h want %h", nm, LAT[i], got[i], exp);
         end
         total++;
         if (busy[i] !== 1'b0) begin
            bad++;
            $display("FAIL %s idle lat%0d: busy got %b want 0", nm, LAT[i], busy[i]);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rdata[i] !== 32'h0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || errf[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset lat%0d: got data=%h busy=%b done=%b err=%b want 0/0/0/0",
                     LAT[i], rdata[i], busy[i], done[i], errf[i]);
         end
      end
   endtask

   task automatic test_core_timing();
      do_write(32'h10, 32'hDEADBEEF);
      mem_addr = 32'h10;
      mem_read = 1'b1;
      tick();
      total++;
      if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin
         bad++;
         $display("FAIL timing_e1: got busy=%b done=%b want 1/0", busy[1], done[1]);
      end
      tick();
      total++;
      if (rdata[1] !== 32'hDEADBEEF || done[1] !== 1'b1) begin
         bad++;
         $display("FAIL timing_e2: got data=%h done=%b want deadbeef/1", rdata[1], done[1]);
      end
      tick();
      total++;
      if (done[1] !== 1'b0 || busy[1] !== 1'b1 || rdata[1] !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL timing_e3: got done=%b busy=%b data=%h want 0/1/deadbeef",
                  done[1], busy[1], rdata[1]);
      end
      mem_read = 1'b0;
      tick();
      total++;
      if (busy[1] !== 1'b0 || errf[1] !== 1'b0) begin
         bad++;
         $display("FAIL timing_release: got busy=%b err=%b want 0/0", busy[1], errf[1]);
      end
   endtask

   task automatic test_read_after_write();
      logic [31:0] old24;
      old24 = $urandom;
      do_write(32'h24, old24);
      do_write(32'h20, 32'h12345678);
      do_read(32'h20, 32'h12345678, 1'b0, 32'h0, "raw");
      do_read(32'h24, old24, 1'b0, 32'h0, "raw_neighbour");
   endtask

   task automatic test_addr_change();
      logic [31:0] v;
      v = $urandom;
      do_write(32'h30, v);
      do_write(32'h10, ~v);
      do_read(32'h10, ~v, 1'b1, 32'h30, "addr_change");
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      d = $urandom;
      do_write(32'h1000, d);
      do_read(32'h0, d, 1'b0, 32'h0, "wrap");
   endtask

   task automatic test_random();
      logic [31:0] a;
      apply_reset();
      for (int k = 0; k < 16; k++)
         do_write(($urandom & 32'hFFFF_F000) | (32'(k) << 2), $urandom);
      for (int n = 0; n < 30; n++) begin
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 1) == 0)
            do_write(a, $urandom);
         else
            do_read(a, model[widx(a)], 1'b0, 32'h0, "random");
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (errf[i] !== 1'b0) begin
            bad++;
            $display("FAIL random_err lat%0d: got %b want 0", LAT[i], errf[i]);
         end
      end
   endtask

   task automatic test_violations();
      logic [31:0] d;
      logic [31:0] old;
      // misaligned read
      apply_reset();
      do_write(32'h10, $urandom);
      do_read(32'h11, model[4], 1'b0, 32'h0, "misaligned");
      for (int i = 0; i < 3; i++) begin
         total++;
         if (errf[i] !== 1'b1) begin
            bad++;
            $display("FAIL misaligned_err lat%0d: got %b want 1", LAT[i], errf[i]);
         end
      end
      // read and write together
      apply_reset();
      d = $urandom;
      mem_addr       = 32'h40;
      mem_write_data = d;
      mem_write      = 1'b1;
      mem_read       = 1'b1;
      tick();
      mem_write = 1'b0;
      mem_read  = 1'b0;
      model[16] = d;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (errf[i] !== 1'b1 || busy[i] !== 1'b0) begin
            bad++;
            $display("FAIL both_high lat%0d: got err=%b busy=%b want 1/0", LAT[i], errf[i], busy[i]);
         end
      end
      tick();
      do_read(32'h40, d, 1'b0, 32'h0, "both_high_data");
      // write while a read is in flight
      apply_reset();
      old = $urandom;
      do_write(32'h44, old);
      mem_addr = 32'h10;
      mem_read = 1'b1;
      tick();
      mem_addr       = 32'h44;
      mem_write_data = ~old;
      mem_write      = 1'b1;
      tick();
      mem_write = 1'b0;
      mem_addr  = 32'h10;
      for (int t = 0; t < 4; t++)
         tick();
      mem_read = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (errf[i] !== 1'b1) begin
            bad++;
            $display("FAIL busy_write_err lat%0d: got %b want 1", LAT[i], errf[i]);
         end
      end
      do_read(32'h44, old, 1'b0, 32'h0, "busy_write_ignored");
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      int          spurious;
      d = $urandom;
      do_write(32'h50, d);
      mem_addr = 32'h50;
      mem_read = 1'b1;
      tick();
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rdata[i] !== 32'h0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || errf[i] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset lat%0d: got data=%h busy=%b done=%b err=%b want 0/0/0/0",
                     LAT[i], rdata[i], busy[i], done[i], errf[i]);
         end
      end
      mem_read = 1'b0;
      tick();
      reset = 1'b1;
      spurious = 0;
      for (int t = 0; t < 5; t++) begin
         tick();
         for (int i = 0; i < 3; i++)
            if (done[i] !== 1'b0)
               spurious++;
      end
      total++;
      if (spurious != 0) begin
         bad++;
         $display("FAIL post_reset_done: got %0d pulses want 0", spurious);
      end
      do_read(32'h50, d, 1'b0, 32'h0, "post_reset_read");
   endtask

   task automatic test_latency();
      logic [31:0] d;
      d = $urandom;
      do_write(32'h10, d);
      mem_addr = 32'h10;
      mem_read = 1'b1;
      tick();
      total++;
      if (done[0] !== 1'b1 || rdata[0] !== d || busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL lat1_accept: got done=%b data=%h busy=%b want 1/%h/1", done[0], rdata[0], busy[0], d);
      end
      mem_read = 1'b0;
      tick();
      tick();
      do_read(32'h10, d, 1'b0, 32'h0, "latency");
   endtask

   initial begin
      reset          = 1'b1;
      mem_addr       = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      test_reset();
      test_core_timing();
      test_read_after_write();
      test_addr_change();
      test_wrap();
      test_random();
      test_violations();
      test_reset_mid_read();
      test_latency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
